// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: word/address type, jump opcode, NOP encoding.
package cpu_pkg;

  typedef logic [15:0] word_t;

  localparam logic [3:0] OPC_JUMP  = 4'b1111;
  localparam word_t      NOP_INSTR = 16'h0000;

  function automatic logic is_jump(input word_t instr);
    return instr[15:12] == OPC_JUMP;
  endfunction

  // Jump target stays inside the current 4K-word page.
  function automatic word_t jump_target(input word_t pc, input word_t instr);
    return {pc[15:12], instr[11:0]};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with priority reset > bubble > load; holds otherwise.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [15:0] instr,
  input  logic [15:0] pc,
  input  logic [15:0] pc_plus1,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= '0;
      if_id_pc_plus1 <= '0;
      if_id_valid    <= 1'b0;
    end else if (load) begin
      if_id_instr    <= instr;
      if_id_pc       <= pc;
      if_id_pc_plus1 <= pc_plus1;
      if_id_valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection with jump predecode, IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rd_data,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid
);

  word_t pc;
  word_t pc_plus1;
  word_t next_pc;
  logic  load;
  logic  bubble;

  assign imem_addr = pc;
  assign pc_plus1  = pc + 16'd1;

  // Redirect beats stall beats jump predecode beats sequential; reset is applied in the registers.
  always_comb begin
    next_pc = pc;
    load    = 1'b0;
    bubble  = 1'b0;
    if (br_taken) begin
      next_pc = br_target;
      bubble  = 1'b1;
    end else if (stall) begin
      next_pc = pc;
    end else if (is_jump(imem_rd_data)) begin
      next_pc = jump_target(pc, imem_rd_data);
      bubble  = 1'b1;
    end else begin
      next_pc = pc_plus1;
      load    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  if_id_reg u_if_id_reg (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .bubble         (bubble),
    .instr          (imem_rd_data),
    .pc             (pc),
    .pc_plus1       (pc_plus1),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: driver queues expected post-edge state, monitor compares.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_rd_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_valid;

  logic [15:0] mem [0:255];

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        valid;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic [15:0] ipc1;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Low page comes from a writable table; one fixed jump lives at 16'h3104.
  assign imem_rd_data = (imem_addr[15:8] == 8'h00) ? mem[imem_addr[7:0]] :
                        (imem_addr == 16'h3104)    ? 16'hF0AB :
                                                     {4'h1, imem_addr[11:0]};

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .imem_addr      (imem_addr),
    .imem_rd_data   (imem_rd_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid)
  );

  function automatic logic [15:0] w(input logic [15:0] a);
    return {4'h1, a[11:0]};
  endfunction

  // Apply inputs for one cycle, then record what the DUT must show after that edge.
  task automatic step(input string name, input logic r, input logic s, input logic b,
                      input logic [15:0] tgt, input logic [15:0] e_pc, input logic e_v,
                      input logic [15:0] e_instr, input logic [15:0] e_ipc);
    exp_t e;
    rst = r; stall = s; br_taken = b; br_target = tgt;
    @(posedge clk);
    e.name  = name;
    e.pc    = e_pc;
    e.valid = e_v;
    e.instr = e_v ? e_instr : 16'h0000;
    e.ipc   = e_v ? e_ipc : 16'h0000;
    e.ipc1  = e_v ? e_ipc + 16'd1 : 16'h0000;
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (imem_addr !== e.pc || if_id_valid !== e.valid || if_id_instr !== e.instr ||
          if_id_pc !== e.ipc || if_id_pc_plus1 !== e.ipc1) begin
        errors++;
        $display("FAIL %s: got pc=%h v=%b instr=%h ipc=%h ipc1=%h, want pc=%h v=%b instr=%h ipc=%h ipc1=%h",
                 e.name, imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1,
                 e.pc, e.valid, e.instr, e.ipc, e.ipc1);
      end
    end
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) mem[i] = w(16'(i));
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;

    step("reset",        1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    step("seq0",         0, 0, 0, 16'h0000, 16'h0001, 1, w(0), 16'h0000);
    step("seq1",         0, 0, 0, 16'h0000, 16'h0002, 1, w(1), 16'h0001);
    step("seq2",         0, 0, 0, 16'h0000, 16'h0003, 1, w(2), 16'h0002);
    step("seq3",         0, 0, 0, 16'h0000, 16'h0004, 1, w(3), 16'h0003);
    for (int i = 0; i < 3; i++)
      step("stall_hold", 0, 1, 0, 16'h0000, 16'h0004, 1, w(3), 16'h0003);
    step("stall_release",0, 0, 0, 16'h0000, 16'h0005, 1, w(4), 16'h0004);
    step("seq5",         0, 0, 0, 16'h0000, 16'h0006, 1, w(5), 16'h0005);
    step("br_with_stall",0, 1, 1, 16'h0009, 16'h0009, 0, 0, 0);
    step("after_br",     0, 0, 0, 16'h0000, 16'h000A, 1, w(9), 16'h0009);
    step("br_ffff",      0, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0);
    step("wrap",         0, 0, 0, 16'h0000, 16'h0000, 1, w(16'hFFFF), 16'hFFFF);
    step("after_wrap",   0, 0, 0, 16'h0000, 16'h0001, 1, w(0), 16'h0000);
    step("br_6",         0, 0, 1, 16'h0006, 16'h0006, 0, 0, 0);
    step("seq6",         0, 0, 0, 16'h0000, 16'h0007, 1, w(6), 16'h0006);
    step("stall_at_7",   0, 1, 0, 16'h0000, 16'h0007, 1, w(6), 16'h0006);
    step("rst_mid_stall",1, 1, 1, 16'h0030, 16'h0000, 0, 0, 0);

    mem[2] = 16'hF005;
    mem[8'h20] = 16'hF020;
    step("refetch0",     0, 0, 0, 16'h0000, 16'h0001, 1, w(0), 16'h0000);
    step("refetch1",     0, 0, 0, 16'h0000, 16'h0002, 1, w(1), 16'h0001);
    step("stall_on_jump",0, 1, 0, 16'h0000, 16'h0002, 1, w(1), 16'h0001);
    step("jump_f005",    0, 0, 0, 16'h0000, 16'h0005, 0, 0, 0);
    step("after_jump",   0, 0, 0, 16'h0000, 16'h0006, 1, w(5), 16'h0005);
    step("br_selfloop",  0, 0, 1, 16'h0020, 16'h0020, 0, 0, 0);
    step("selfloop1",    0, 0, 0, 16'h0000, 16'h0020, 0, 0, 0);
    step("selfloop2",    0, 0, 0, 16'h0000, 16'h0020, 0, 0, 0);
    step("br_over_jump", 0, 0, 1, 16'h0040, 16'h0040, 0, 0, 0);
    step("br_3104",      0, 0, 1, 16'h3104, 16'h3104, 0, 0, 0);
    step("jump_paged",   0, 0, 0, 16'h0000, 16'h30AB, 0, 0, 0);
    step("after_paged",  0, 0, 0, 16'h0000, 16'h30AC, 1, w(16'h30AB), 16'h30AB);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Port: clk  in  1  single rising-edge clock for all state.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: stall  in  1  hazard unit hold; freeze PC and IF/ID.
REQ-005 Port: br_taken  in  1  EX-stage redirect; squash younger fetch.
REQ-006 Port: br_target  in  16  word address for redirect.
REQ-007 Port: imem_addr  out  16  instruction memory address (combinational, equals PC).
REQ-008 Port: imem_rd_data  in  16  instruction word, valid in the same cycle as imem_addr (asynchronous read).
REQ-009 Port: if_id_instr  out  16  registered instruction to decode.
REQ-010 Port: if_id_pc  out  16  registered PC of if_id_instr.
REQ-011 Port: if_id_pc_plus1  out  16  registered PC+1 of if_id_instr.
REQ-012 Port: if_id_valid  out  1  1 = if_id_instr is a real instruction; 0 = bubble.

Function
REQ-013 PC shall be word-addressed; sequential next PC = PC + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-014 imem_addr shall equal the PC register at all times; no read-enable or write path to memory.
REQ-015 Jump predecode: imem_rd_data[15:12] == OPC_JUMP (4'b1111) shall be treated as an unconditional jump with target {PC[15:12], imem_rd_data[11:0]}.
REQ-016 Next-PC priority per cycle: rst > br_taken > stall > fetched jump > sequential.
REQ-017 br_taken=1: PC <= br_target; IF/ID <= bubble, regardless of stall.
REQ-018 stall=1, br_taken=0: PC and all if_id_* outputs hold their values.
REQ-019 Fetched jump, no stall, no branch: PC <= jump target; IF/ID <= bubble; the jump costs zero extra cycles.
REQ-020 Normal: PC <= PC+1; if_id_instr <= imem_rd_data, if_id_pc <= PC, if_id_pc_plus1 <= PC+1, if_id_valid <= 1.
REQ-021 Bubble: if_id_instr = 16'h0000 (NOP), if_id_valid = 0, if_id_pc and if_id_pc_plus1 = 16'h0000.
REQ-022 Fetch-to-decode latency shall be exactly one clock.
REQ-023 Jump to own address (self-loop) shall refetch indefinitely and emit only bubbles.

Reset
REQ-024 On a clock edge with rst=1: PC <= RESET_PC; if_id_instr <= 16'h0000; if_id_pc <= 0; if_id_pc_plus1 <= 0; if_id_valid <= 0.
REQ-025 rst shall override stall and br_taken in the same cycle; reset mid-stall or mid-redirect discards all pending state.
REQ-026 The first fetch after rst deasserts shall be from RESET_PC.

Structure
REQ-027 OPC_JUMP, NOP_INSTR (16'h0000), and the 16-bit word/address typedef shall live in shared package cpu_pkg.
REQ-028 The IF/ID register shall be a sub-module if_id_reg (load, bubble and hold controls); PC and next-PC selection remain in fetch_stage.
REQ-029 Implementation shall be synthesizable: no initial blocks and no latches.

Verification
REQ-030 Reset, then free-run with non-jump words at addresses 0..3 -> imem_addr 0,1,2,3; if_id_pc 0,1,2 one cycle later, valid=1.
REQ-031 Word 16'hF005 at PC 16'h0002 -> next PC 16'h0005; IF/ID bubble (valid=0) for that cycle; instruction at 5 appears one cycle later.
REQ-032 stall=1 for 3 cycles at PC 4 -> PC stays 4, if_id_* unchanged; resume at PC 5 on release.
REQ-033 br_taken=1, br_target=16'h0009, with stall=1 simultaneously -> PC=9 next cycle, if_id_valid=0.
REQ-034 PC forced to 16'hFFFF via branch, non-jump fetch -> next PC 16'h0000, if_id_pc_plus1 = 16'h0000.
REQ-035 rst asserted during a stall at PC 7 -> PC=RESET_PC, if_id_valid=0 on the next edge.
